// File: rtl/dma_fifo_pkg.sv
// Shared sizing and write-size encodings for the DMA byte-packing FIFO.
package dma_fifo_pkg;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = 3;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_WORD = 2'b01,
    SZ_LONG = 2'b10
  } size_e;

endpackage

// File: rtl/dma_fifo_ram.sv
// 8x32 register file with per-byte-lane write enables and one async read port.
module dma_fifo_ram
  import dma_fifo_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [PTR_W-1:0] i_waddr,
  input  logic [LANES-1:0] i_be,
  input  logic [31:0]      i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // i_be[b] enables bits [8b+7:8b]; lane 0 (big-endian) is i_be[3]
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int unsigned b = 0; b < LANES; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dma_fifo.sv
// DMA FIFO: packs byte/word/longword writes into 32-bit entries, pops whole entries.
module dma_fifo
  import dma_fifo_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_,
  input  logic [31:0]      FIFO_ID,
  input  logic             WE,
  input  logic [1:0]       SIZE,
  input  logic             RE,
  input  logic             FLUSH,
  input  logic             CLR,
  output logic [31:0]      FIFO_OD,
  output logic             BO0,
  output logic             BO1,
  output logic             FULL,
  output logic             EMPTY,
  output logic [CNT_W-1:0] COUNT
);

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [1:0]       r_bo;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_empty;
  logic [LANES-1:0] w_be;
  logic [1:0]       w_bo_nxt;
  logic             w_commit;
  logic             w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Write lanes first, then flush on the post-write offset so one cycle commits at most once.
  always_comb begin
    w_be     = '0;
    w_bo_nxt = r_bo;
    w_commit = 1'b0;
    if (WE && !CLR && !w_full) begin
      case (SIZE)
        SZ_BYTE: begin
          w_be     = 4'b1000 >> r_bo;
          w_bo_nxt = r_bo + 2'd1;
          w_commit = (r_bo == 2'd3);
        end
        SZ_WORD: begin
          if (!r_bo[0]) begin
            w_be     = 4'b1100 >> r_bo;
            w_bo_nxt = r_bo + 2'd2;
            w_commit = (r_bo == 2'd2);
          end
        end
        SZ_LONG: begin
          if (r_bo == 2'd0) begin
            w_be     = '1;
            w_commit = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (FLUSH && !CLR && (w_bo_nxt != 2'd0)) begin
      w_bo_nxt = 2'd0;
      w_commit = 1'b1;
    end
  end

  assign w_pop = RE && !CLR && !w_empty;

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_bo    <= '0;
      r_count <= '0;
    end else if (CLR) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_bo    <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PTR_W'(w_commit);
      r_rptr  <= r_rptr + PTR_W'(w_pop);
      r_bo    <= w_bo_nxt;
      r_count <= r_count + CNT_W'(w_commit) - CNT_W'(w_pop);
    end
  end

  dma_fifo_ram u_ram (
    .i_clk   (CLK),
    .i_rst_n (RST_),
    .i_waddr (r_wptr),
    .i_be    (w_be),
    .i_wdata (FIFO_ID),
    .i_raddr (r_rptr),
    .o_rdata (FIFO_OD)
  );

  assign BO0   = r_bo[0];
  assign BO1   = r_bo[1];
  assign FULL  = w_full;
  assign EMPTY = w_empty;
  assign COUNT = r_count;

endmodule

// File: tb/tb_dma_fifo.sv
// Directed and randomized checks of dma_fifo against a commit/pop-total reference model.
module tb_dma_fifo;

  logic        CLK = 1'b0;
  logic        RST_ = 1'b0;
  logic [31:0] FIFO_ID = '0;
  logic        WE = 1'b0;
  logic [1:0]  SIZE = 2'b00;
  logic        RE = 1'b0;
  logic        FLUSH = 1'b0;
  logic        CLR = 1'b0;
  logic [31:0] FIFO_OD;
  logic        BO0, BO1, FULL, EMPTY;
  logic [3:0]  COUNT;

  dma_fifo dut (
    .CLK(CLK), .RST_(RST_), .FIFO_ID(FIFO_ID), .WE(WE), .SIZE(SIZE), .RE(RE),
    .FLUSH(FLUSH), .CLR(CLR), .FIFO_OD(FIFO_OD), .BO0(BO0), .BO1(BO1),
    .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_bad = 0;

  // Model: storage image plus running totals of commits/pops; offset counted in bytes.
  logic [31:0] m_mem [8];
  int unsigned m_wr, m_rd, m_bo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_wr = 0; m_rd = 0; m_bo = 0;
  endtask

  task automatic put_lane(input int unsigned slot, input int unsigned k, input logic [31:0] d);
    logic [31:0] mask;
    mask = 32'hFF00_0000 >> (8 * k);
    m_mem[slot] = (m_mem[slot] & ~mask) | (d & mask);
  endtask

  task automatic model_step(input logic we, input logic [1:0] sz, input logic re,
                            input logic fl, input logic cl, input logic [31:0] d);
    int unsigned cnt, nb;
    bit commit;
    if (cl) begin
      m_wr = 0; m_rd = 0; m_bo = 0;
      return;
    end
    cnt = m_wr - m_rd;
    commit = 0;
    if (we && cnt != 8) begin
      nb = 0;
      if (sz == 2'd0) nb = 1;
      else if (sz == 2'd1 && (m_bo % 2) == 0) nb = 2;
      else if (sz == 2'd2 && m_bo == 0) nb = 4;
      for (int unsigned k = m_bo; k < m_bo + nb; k++) put_lane(m_wr % 8, k, d);
      if (nb != 0) begin
        m_bo += nb;
        if (m_bo == 4) begin m_bo = 0; commit = 1; end
      end
    end
    if (fl && m_bo != 0) begin m_bo = 0; commit = 1; end
    if (re && cnt != 0) m_rd++;
    if (commit) m_wr++;
  endtask

  task automatic check_outputs(input string tag);
    int unsigned cnt;
    cnt = m_wr - m_rd;
    check({tag, ".od"},    FIFO_OD, m_mem[m_rd % 8]);
    check({tag, ".count"}, {28'b0, COUNT}, cnt);
    check({tag, ".empty"}, {31'b0, EMPTY}, (cnt == 0) ? 32'd1 : 32'd0);
    check({tag, ".full"},  {31'b0, FULL},  (cnt == 8) ? 32'd1 : 32'd0);
    check({tag, ".bo"},    {30'b0, BO1, BO0}, m_bo);
  endtask

  task automatic cyc(input string tag, input logic we, input logic [1:0] sz, input logic re,
                     input logic fl, input logic cl, input logic [31:0] d);
    WE = we; SIZE = sz; RE = re; FLUSH = fl; CLR = cl; FIFO_ID = d;
    @(posedge CLK);
    model_step(we, sz, re, fl, cl, d);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 2'd0, 0, 0, 0, 32'h0);
  endtask

  // Pulse reset between edges; outputs must clear without waiting for a clock.
  task automatic reset_pulse(input string tag);
    #2 RST_ = 1'b0;
    WE = 0; RE = 0; FLUSH = 0; CLR = 0;
    model_reset();
    #1;
    check_outputs(tag);
    check({tag, ".od0"}, FIFO_OD, 32'h0);
    @(negedge CLK);
    RST_ = 1'b1;
  endtask

  logic [31:0] bytes4 [4];

  initial begin
    model_reset();
    #3;
    check_outputs("rst");
    @(negedge CLK);
    RST_ = 1'b1;

    // four byte writes into their own lanes
    bytes4[0] = 32'h1100_0000; bytes4[1] = 32'h0022_0000;
    bytes4[2] = 32'h0000_3300; bytes4[3] = 32'h0000_0044;
    for (int i = 0; i < 4; i++) begin
      cyc("byte4", 1, 2'd0, 0, 0, 0, bytes4[i]);
      check("byte4.bo_step", {30'b0, BO1, BO0}, (i + 1) % 4);
    end
    check("byte4.count", {28'b0, COUNT}, 32'd1);
    check("byte4.od", FIFO_OD, 32'h1122_3344);

    // nine longwords, ninth dropped by FULL, then drain
    cyc("clr", 0, 2'd0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 9; i++) begin
      cyc("long9", 1, 2'd2, 0, 0, 0, i);
      if (i == 7) check("long9.full", {31'b0, FULL}, 32'd1);
    end
    check("long9.count", {28'b0, COUNT}, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("pop.data", FIFO_OD, i);
      cyc("pop", 0, 2'd0, 1, 0, 0, 32'h0);
    end
    check("pop.empty", {31'b0, EMPTY}, 32'd1);

    // word + byte + flush
    cyc("clr", 0, 2'd0, 0, 0, 1, 32'h0);
    cyc("wbf", 1, 2'd1, 0, 0, 0, 32'hAAAA_0000);
    cyc("wbf", 1, 2'd0, 0, 0, 0, 32'h0000_BB00);
    cyc("wbf", 0, 2'd0, 0, 1, 0, 32'h0);
    check("wbf.count", {28'b0, COUNT}, 32'd1);
    check("wbf.bo", {30'b0, BO1, BO0}, 32'd0);
    check("wbf.od", {8'h00, FIFO_OD[31:8]}, 32'h00AA_AABB);

    // misaligned word at BO=1, misaligned longword at BO=2
    cyc("mis", 1, 2'd0, 0, 0, 0, 32'h5500_0000);
    cyc("mis.word", 1, 2'd1, 0, 0, 0, 32'hFFFF_FFFF);
    cyc("mis", 1, 2'd0, 0, 0, 0, 32'h0066_0000);
    cyc("mis.long", 1, 2'd2, 0, 0, 0, 32'hFFFF_FFFF);
    cyc("mis.rsvd", 1, 2'd3, 0, 0, 0, 32'hFFFF_FFFF);
    check("mis.bo", {30'b0, BO1, BO0}, 32'd2);

    // COUNT=3 with commit + pop in one cycle
    cyc("clr", 0, 2'd0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 3; i++) cyc("c3", 1, 2'd2, 0, 0, 0, 32'hC000_0000 + i);
    cyc("c3", 1, 2'd1, 0, 0, 0, 32'h1234_0000);
    cyc("c3.both", 1, 2'd1, 1, 0, 0, 32'h0000_5678);
    check("c3.count", {28'b0, COUNT}, 32'd3);

    // FULL with write + pop: only the pop happens
    for (int i = 0; i < 5; i++) cyc("fill", 1, 2'd2, 0, 0, 0, 32'hF000_0000 + i);
    cyc("full.both", 1, 2'd2, 1, 0, 0, 32'hDEAD_BEEF);
    check("full.count", {28'b0, COUNT}, 32'd7);

    // EMPTY with first commit + pop: pop ignored
    cyc("clr", 0, 2'd0, 0, 0, 1, 32'h0);
    cyc("emp", 1, 2'd1, 0, 0, 0, 32'hABCD_0000);
    cyc("emp.both", 1, 2'd1, 1, 0, 0, 32'h0000_EF01);
    check("emp.count", {28'b0, COUNT}, 32'd1);

    // CLR with BO=2, COUNT=5 overriding other requests
    for (int i = 0; i < 4; i++) cyc("pre", 1, 2'd2, 0, 0, 0, 32'h0707_0000 + i);
    cyc("pre", 1, 2'd1, 0, 0, 0, 32'h9999_0000);
    check("pre.count", {28'b0, COUNT}, 32'd5);
    cyc("clr.ovr", 1, 2'd1, 1, 1, 1, 32'h1111_2222);
    check("clr.count", {28'b0, COUNT}, 32'd0);
    check("clr.bo", {30'b0, BO1, BO0}, 32'd0);

    // reset mid-entry
    cyc("rm", 1, 2'd2, 0, 0, 0, 32'h4242_4242);
    cyc("rm", 1, 2'd0, 0, 0, 0, 32'h7700_0000);
    reset_pulse("rst.mid");
    cyc("post_rst", 1, 2'd2, 0, 0, 0, 32'h0BAD_F00D);
    check("post_rst.count", {28'b0, COUNT}, 32'd1);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic we, re, fl, cl;
      logic [1:0] sz;
      we = ($urandom_range(0, 9) < 6);
      re = ($urandom_range(0, 9) < 4);
      fl = ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 63) == 0);
      sz = 2'($urandom_range(0, 3));
      if (n % 500 == 499) reset_pulse("rand.rst");
      else cyc("rand", we, sz, re, fl, cl, $urandom);
    end
    idle("end");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_fifo.md
DMA_FIFO -- requirements
Module: dma_fifo

Interface
REQ-001 CLK  input  1  single system clock; all state changes on rising edge.
REQ-002 RST_  input  1  asynchronous, active-low reset.
REQ-003 FIFO_ID  input  32  write data from datapath; byte lane 0 = bits 31:24 (big-endian).
REQ-004 WE  input  1  write request, sampled each cycle.
REQ-005 SIZE  input  2  write size: 00 byte, 01 word, 10 longword, 11 reserved (write ignored).
REQ-006 RE  input  1  pop request; advances read pointer.
REQ-007 FLUSH  input  1  commit the partially filled entry.
REQ-008 CLR  input  1  synchronous clear of pointers and count.
REQ-009 FIFO_OD  output  32  entry at read pointer, combinational from storage.
REQ-010 BO0, BO1  output  1 each  current byte offset within the write entry (BO1 = MSB), fed to SCSI datapath.
REQ-011 FULL  output  1  count == 8.
REQ-012 EMPTY  output  1  count == 0.
REQ-013 COUNT  output  4  committed longwords, 0..8.

Function
REQ-014 Storage SHALL be 8 entries x 32 bits with 3-bit write pointer WPTR, 3-bit read pointer RPTR, 2-bit byte offset BO, 4-bit COUNT; pointers wrap 7->0.
REQ-015 Byte write: lane BO written from the same lane of FIFO_ID; BO += 1.
REQ-016 Word write: accepted only if BO0 = 0; writes lanes {BO1,0},{BO1,1}; BO += 2.
REQ-017 Longword write: accepted only if BO = 00; writes all lanes; entry committed.
REQ-018 An entry SHALL commit when BO wraps to 00 or on a longword write: WPTR += 1, COUNT += 1, same edge.
REQ-019 Misaligned or reserved-size writes SHALL be ignored with no state change.
REQ-020 Writes SHALL be ignored when FULL is 1 at the start of the cycle, even if RE is also asserted.
REQ-021 RE with EMPTY = 1 SHALL be ignored, including a cycle in which a write commits the first entry.
REQ-022 A commit and an accepted pop in the same cycle SHALL leave COUNT unchanged and advance both pointers.
REQ-023 FLUSH with BO != 00 SHALL commit the partial entry (unwritten lanes retain prior contents) and set BO = 00.
REQ-024 FLUSH with BO = 00 SHALL be a no-op.
REQ-025 FLUSH and WE in the same cycle: the write is applied first, then the flush; at most one commit per cycle.
REQ-026 CLR SHALL zero WPTR, RPTR, BO and COUNT, and SHALL override WE, RE and FLUSH.
REQ-027 CLR SHALL leave storage contents unchanged.
REQ-028 FIFO_OD, FULL, EMPTY, COUNT, BO0 and BO1 SHALL reflect state with zero added latency after the clock edge.

Reset
REQ-029 RST_ low SHALL clear all pointers, BO, COUNT and all storage to 0, asynchronously.
REQ-030 During reset: FIFO_OD = 0, EMPTY = 1, FULL = 0, COUNT = 0, BO0 = BO1 = 0.
REQ-031 Reset asserted mid-entry SHALL discard the partial entry.
REQ-032 Deassertion SHALL be recognised on the next rising CLK edge; the first operation is accepted on that edge.

Structure
REQ-033 Package dma_fifo_pkg SHALL hold:
- DEPTH = 8, pointer width 3, count width 4;
- SIZE encodings SZ_BYTE, SZ_WORD, SZ_LONG.
REQ-034 Storage SHALL be a sub-module dma_fifo_ram: 8x32 register file, 4 byte-lane write enables, one async read port, async reset. Pointer/BO/count control stays in dma_fifo.

Verification
REQ-035 Four byte writes 0x11,0x22,0x33,0x44 (each in its lane) -> BO steps 1,2,3,0; COUNT = 1; FIFO_OD = 0x11223344.
REQ-036 Nine longword writes 0x0..0x8 -> FULL after the eighth; ninth ignored; eight pops return 0x0..0x7; EMPTY = 1.
REQ-037 Word 0xAAAA then byte 0xBB, then FLUSH -> COUNT = 1, BO = 00, FIFO_OD[31:8] = 0xAAAABB.
REQ-038 Misaligned writes -> no state change:
- BO = 01 with word write;
- BO = 10 with longword write.
REQ-039 Same-cycle operations:
- COUNT = 3: commit + pop -> COUNT stays 3;
- FULL: write + pop -> pop only, COUNT = 7;
- EMPTY: commit + pop -> COUNT = 1.
REQ-040 Clear and reset mid-entry:
- CLR with BO = 10, COUNT = 5 -> all zero;
- RST_ pulse mid-entry -> FIFO_OD = 0, EMPTY = 1, immediately (asynchronously).
